johnson_phase_monitor: RTL and testbench

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

---
 rtl/johnson_phase_monitor.sv | 144 ++++++++++++++
 tb/tb_johnson_phase_monitor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/johnson_phase_monitor.sv
// Decodes a 4-bit Johnson code into a phase and tracks lock/sequence health.
// Two-stage pipeline: input register, then decode into registered outputs and FSM.
module johnson_phase_monitor #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count_in,
    input  logic             clr_err,
    output logic [7:0]       phase,
    output logic [2:0]       phase_idx,
    output logic             valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t     state, state_n;
    logic [3:0] cnt_q;
    logic       cnt_v;
    logic [3:0] good, good_n, good_inc;
    logic [2:0] prev_idx, prev_n;
    logic [2:0] code_idx;
    logic       code_ok;
    logic       is_succ, is_hold;
    logic       seq_n;

    always_comb begin
        code_ok  = 1'b1;
        code_idx = '0;
        case (cnt_q)
            4'b0000: code_idx = 3'd0;
            4'b0001: code_idx = 3'd1;
            4'b0011: code_idx = 3'd2;
            4'b0111: code_idx = 3'd3;
            4'b1111: code_idx = 3'd4;
            4'b1110: code_idx = 3'd5;
            4'b1100: code_idx = 3'd6;
            4'b1000: code_idx = 3'd7;
            default: code_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        good_n   = good;
        prev_n   = prev_idx;
        seq_n    = 1'b0;
        good_inc = good + 4'd1;
        is_succ  = (code_idx == 3'(prev_idx + 3'd1));
        is_hold  = (code_idx == prev_idx);
        // cnt_q holds no real sample until the first edge after reset release
        if (cnt_v) begin
            if (code_ok) begin
                prev_n = code_idx;
            end
            case (state)
                IDLE: begin
                    if (code_ok) begin
                        state_n = ACQ;
                        good_n  = '0;
                    end
                end
                ACQ: begin
                    if (!code_ok) begin
                        state_n = IDLE;
                        good_n  = '0;
                    end else if (is_succ) begin
                        good_n = good_inc;
                        if (good_inc == LOCK_TGT) begin
                            state_n = LOCK;
                        end
                    end else if (!is_hold) begin
                        seq_n  = 1'b1;
                        good_n = '0;
                    end
                end
                LOCK: begin
                    if (!code_ok) begin
                        state_n = IDLE;
                        good_n  = '0;
                    end else if (!(is_succ || is_hold)) begin
                        seq_n   = 1'b1;
                        state_n = ACQ;
                        good_n  = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    good_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            cnt_v     <= 1'b0;
            state     <= IDLE;
            good      <= '0;
            prev_idx  <= '0;
            phase     <= '0;
            phase_idx <= '0;
            valid     <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            cnt_q    <= count_in;
            cnt_v    <= 1'b1;
            state    <= state_n;
            good     <= good_n;
            prev_idx <= prev_n;
            if (cnt_v) begin
                valid   <= code_ok;
                illegal <= !code_ok;
                seq_err <= seq_n;
                locked  <= (state_n == LOCK);
                phase   <= code_ok ? (8'd1 << code_idx) : '0;
                if (code_ok) begin
                    phase_idx <= code_idx;
                end
            end
            if (clr_err) begin
                err_cnt <= '0;
            end else if (cnt_v && (!code_ok || seq_n) && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench: lock, wrap, skip, illegal, async reset on a default instance,
// saturation and clear on a narrow-counter instance.
module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count_in = 4'b0000;
    logic       clr_err = 1'b0;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       valid, illegal, seq_err, locked;
    logic [7:0] err_cnt;

    logic [3:0] count_in2 = 4'b0000;
    logic       clr_err2 = 1'b0;
    logic [7:0] phase2;
    logic [2:0] phase_idx2;
    logic       valid2, illegal2, seq_err2, locked2;
    logic [1:0] err_cnt2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    johnson_phase_monitor #(.LOCK_CNT(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
        .phase(phase), .phase_idx(phase_idx), .valid(valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    johnson_phase_monitor #(.LOCK_CNT(4), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .count_in(count_in2), .clr_err(clr_err2),
        .phase(phase2), .phase_idx(phase_idx2), .valid(valid2), .illegal(illegal2),
        .seq_err(seq_err2), .locked(locked2), .err_cnt(err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] c);
        count_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [3:0] c, input logic clr);
        count_in2 = c;
        clr_err2  = clr;
        @(posedge clk);
        #1;
    endtask

    // {phase, phase_idx, valid, illegal, seq_err, locked, err_cnt}
    task automatic check_all(input string tag, input logic [7:0] ph, input logic [2:0] ix,
                             input logic v, input logic il, input logic se, input logic lk,
                             input logic [7:0] ec);
        check({tag, ".phase"}, 32'(phase), 32'(ph));
        check({tag, ".idx"}, 32'(phase_idx), 32'(ix));
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".illegal"}, 32'(illegal), 32'(il));
        check({tag, ".seq_err"}, 32'(seq_err), 32'(se));
        check({tag, ".locked"}, 32'(locked), 32'(lk));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    endtask

    initial begin
        #12;
        check_all("reset", 8'h00, 3'd0, 0, 0, 0, 0, 8'd0);
        rst = 1'b1;
        #1;

        // acquire and lock
        step(4'b0000);
        step(4'b0001); check_all("acq0", 8'h01, 3'd0, 1, 0, 0, 0, 8'd0);
        step(4'b0011); check_all("acq1", 8'h02, 3'd1, 1, 0, 0, 0, 8'd0);
        step(4'b0111); check_all("acq2", 8'h04, 3'd2, 1, 0, 0, 0, 8'd0);
        step(4'b1111); check_all("acq3", 8'h08, 3'd3, 1, 0, 0, 0, 8'd0);
        step(4'b1111); check_all("lock4", 8'h10, 3'd4, 1, 0, 0, 1, 8'd0);

        // hold, then wrap 7->0
        step(4'b1110); check_all("hold4", 8'h10, 3'd4, 1, 0, 0, 1, 8'd0);
        step(4'b1100); check_all("lk5", 8'h20, 3'd5, 1, 0, 0, 1, 8'd0);
        step(4'b1000); check_all("lk6", 8'h40, 3'd6, 1, 0, 0, 1, 8'd0);
        step(4'b0000); check_all("lk7", 8'h80, 3'd7, 1, 0, 0, 1, 8'd0);
        step(4'b0001); check_all("wrap0", 8'h01, 3'd0, 1, 0, 0, 1, 8'd0);
        step(4'b0011); check_all("lk1", 8'h02, 3'd1, 1, 0, 0, 1, 8'd0);
        step(4'b1111); check_all("lk2", 8'h04, 3'd2, 1, 0, 0, 1, 8'd0);

        // skip from 2 to 4
        step(4'b1111); check_all("skip", 8'h10, 3'd4, 1, 0, 1, 0, 8'd1);
        step(4'b1110); check_all("skip_hold", 8'h10, 3'd4, 1, 0, 0, 0, 8'd1);
        step(4'b0101); check_all("acq5", 8'h20, 3'd5, 1, 0, 0, 0, 8'd1);

        // illegal codes
        step(4'b0101); check_all("ill1", 8'h00, 3'd5, 0, 1, 0, 0, 8'd2);
        step(4'b1100); check_all("ill2", 8'h00, 3'd5, 0, 1, 0, 0, 8'd3);

        // re-lock from IDLE starting at 6
        step(4'b1000); check_all("re6", 8'h40, 3'd6, 1, 0, 0, 0, 8'd3);
        step(4'b0000); check_all("re7", 8'h80, 3'd7, 1, 0, 0, 0, 8'd3);
        step(4'b0001); check_all("re0", 8'h01, 3'd0, 1, 0, 0, 0, 8'd3);
        step(4'b0011); check_all("re1", 8'h02, 3'd1, 1, 0, 0, 0, 8'd3);
        step(4'b0011); check_all("re2", 8'h04, 3'd2, 1, 0, 0, 1, 8'd3);

        // asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 3'd0, 0, 0, 0, 0, 8'd0);
        #3;
        rst = 1'b1;
        #1;

        // first sample after release: 0011 must not raise seq_err
        step(4'b0011);
        step(4'b0111); check_all("first", 8'h04, 3'd2, 1, 0, 0, 0, 8'd0);
        step(4'b1111); check_all("first_next", 8'h08, 3'd3, 1, 0, 0, 0, 8'd0);

        // saturation and clear on the 2-bit counter
        check("sat.start", 32'(err_cnt2), 32'd0);
        for (int i = 0; i < 5; i++) step2(4'b0101, 1'b0);
        step2(4'b0101, 1'b0);
        check("sat.err", 32'(err_cnt2), 32'd3);
        check("sat.illegal", 32'(illegal2), 32'd1);
        step2(4'b0101, 1'b1);
        check("sat.clr", 32'(err_cnt2), 32'd0);
        step2(4'b0101, 1'b0);
        check("sat.resume", 32'(err_cnt2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
